// File: rtl/riscv_enc_pkg.sv
// Shared encoder constants: RV32I opcodes, bundle kinds, funct3 values, loader FSM states.
// Pure declarations, no logic or latency of its own.
// No flow control here; it is consumed by instr_field_packer and instr_encode_loader.
package riscv_enc_pkg;

  // Major opcodes for the four supported instruction kinds
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Encoding of the in_kind field
  localparam logic [1:0] KIND_LW  = 2'b00;
  localparam logic [1:0] KIND_SW  = 2'b01;
  localparam logic [1:0] KIND_R   = 2'b10;
  localparam logic [1:0] KIND_BEQ = 2'b11;

  // funct3 values fixed by the kind (word load/store, beq)
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCEPT = 2'b01,
    ST_WRITE  = 2'b10,
    ST_DONE   = 2'b11
  } ld_state_t;

  // One instruction field bundle as presented on the input handshake
  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [12:0] imm;
  } fields_t;

  // A branch offset with bit 0 set cannot be represented in the B-type encoding
  function automatic logic beq_misaligned(input fields_t f);
    return (f.kind == KIND_BEQ) && f.imm[0];
  endfunction

endpackage

// File: rtl/instr_encode_loader_packer.sv
// Packs one field bundle into a 32-bit RV32I instruction word (lw, sw, R-type, beq).
// Purely combinational, zero latency.
// No flow control; the caller decides when the word is captured.
module instr_field_packer
  import riscv_enc_pkg::*;
(
  input  fields_t     fields_i,
  output logic [31:0] word_o
);

  // Bit 0 of a branch offset is implicit in the B-type format and never encoded
  logic unused_imm_lsb;
  assign unused_imm_lsb = fields_i.imm[0];

  // Select the instruction format by kind; fields a kind does not use are ignored
  always_comb begin
    word_o = '0;
    case (fields_i.kind)
      KIND_LW:  word_o = {fields_i.imm[11:0], fields_i.rs1, F3_W, fields_i.rd, OP_LW};
      KIND_SW:  word_o = {fields_i.imm[11:5], fields_i.rs2, fields_i.rs1, F3_W,
                          fields_i.imm[4:0], OP_SW};
      KIND_R:   word_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3,
                          fields_i.rd, OP_R};
      KIND_BEQ: word_o = {fields_i.imm[12], fields_i.imm[10:5], fields_i.rs2, fields_i.rs1,
                          F3_BEQ, fields_i.imm[4:1], fields_i.imm[11], OP_BEQ};
      default:  word_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Sequential program loader: encodes field bundles and writes them to consecutive imem words.
// A bundle accepted at edge N is written during cycle N+1; one word per 2 cycles.
// in_ready is high only in ACCEPT, so the source stalls during WRITE, IDLE and DONE.
// Optional ENCLD_BRANCH_CHECK_EN: beq with an odd offset is dropped and raises sticky err.
module instr_encode_loader
  import riscv_enc_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  ld_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  fields_t           in_fields;
  logic [31:0]       packed_word;
  logic              accept;
  logic              bad_branch;
  logic              session_end;

  assign in_fields = '{kind:   in_kind,
                       rd:     in_rd,
                       rs1:    in_rs1,
                       rs2:    in_rs2,
                       funct3: in_funct3,
                       funct7: in_funct7,
                       imm:    in_imm};

  instr_field_packer u_packer (
    .fields_i (in_fields),
    .word_o   (packed_word)
  );

  assign accept = (state_q == ST_ACCEPT) && in_valid;

`ifdef ENCLD_BRANCH_CHECK_EN
  assign bad_branch = beq_misaligned(in_fields);
`else
  assign bad_branch = 1'b0;
`endif

  // The write in flight closes the session if it was tagged last or fills the session
  assign session_end = last_q || ((count_q + CNT_ONE) == DEPTH_C);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: pointer, counter, captured word/last flag, sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= BASE_C;
      count_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; start only matters in IDLE/DONE, in_valid only in ACCEPT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        if (accept) begin
          if (bad_branch) state_d = in_last ? ST_DONE : ST_ACCEPT;
          else            state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = session_end ? ST_DONE : ST_ACCEPT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: session init on start, capture on accept, advance after write
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          ptr_d   = BASE_C;
          count_d = '0;
          err_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      ST_ACCEPT: begin
        if (accept) begin
          if (bad_branch) begin
            err_d = 1'b1;
          end else begin
            word_d = packed_word;
            last_d = in_last;
          end
        end
      end
      ST_WRITE: begin
        ptr_d   = ptr_q + PTR_ONE;
        count_d = count_q + CNT_ONE;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; write address/data are zero outside the write cycle
  always_comb begin
    in_ready   = (state_q == ST_ACCEPT);
    imem_we    = (state_q == ST_WRITE);
    imem_addr  = imem_we ? ptr_q : '0;
    imem_wdata = imem_we ? word_q : '0;
    busy       = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    done       = (state_q == ST_DONE);
    full       = (count_q == DEPTH_C);
    count      = count_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: directed scenarios plus randomized sessions.
// Expected words come from an arithmetic encoder model; session bookkeeping from a small model.
// Inputs are driven just after edges and outputs sampled on the falling edge.
module tb_instr_encode_loader;

  localparam int ADDR_W    = 6;
  localparam int DEPTH     = 4;
  localparam int BASE_ADDR = 0;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [12:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              busy, done, full, err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model of the session
  int exp_ptr;
  int exp_cnt;
  bit exp_err;
  bit exp_done;
`ifdef ENCLD_BRANCH_CHECK_EN
  bit branch_chk = 1'b1;
`else
  bit branch_chk = 1'b0;
`endif

  instr_encode_loader #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // RV32I encoding built from field positions with shifts and adds
  function automatic logic [31:0] ref_encode(input int kind, input int rd, input int rs1,
                                             input int rs2, input int f3, input int f7,
                                             input int imm);
    logic [31:0] w;
    case (kind)
      0: w = ((imm & 'hfff) << 20) + (rs1 << 15) + (2 << 12) + (rd << 7) + 'h03;
      1: w = (((imm >> 5) & 'h7f) << 25) + (rs2 << 20) + (rs1 << 15) + (2 << 12)
             + ((imm & 'h1f) << 7) + 'h23;
      2: w = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33;
      default: w = (((imm >> 12) & 1) << 31) + (((imm >> 5) & 'h3f) << 25) + (rs2 << 20)
             + (rs1 << 15) + (((imm >> 1) & 'hf) << 8) + (((imm >> 11) & 1) << 7) + 'h63;
    endcase
    return w;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    imem_we,    0);
    check({tag, "_addr"},  imem_addr,  0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_count"}, count,      0);
    check({tag, "_busy"},  busy,       0);
    check({tag, "_done"},  done,       0);
    check({tag, "_full"},  full,       0);
    check({tag, "_err"},   err,        0);
    check({tag, "_rdy"},   in_ready,   0);
  endtask

  task automatic model_reset();
    exp_ptr  = BASE_ADDR;
    exp_cnt  = 0;
    exp_err  = 1'b0;
    exp_done = 1'b0;
  endtask

  // Called on a falling edge; returns on a falling edge
  task automatic do_start(input bit with_valid);
    start    = 1'b1;
    in_valid = with_valid;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    model_reset();
    check("start_we",    imem_we,  0);
    check("start_busy",  busy,     1);
    check("start_rdy",   in_ready, 1);
    check("start_count", count,    0);
    check("start_done",  done,     0);
    check("start_full",  full,     0);
    check("start_err",   err,      0);
  endtask

  task automatic drive_fields(input int kind, input int rd, input int rs1, input int rs2,
                              input int f3, input int f7, input int imm, input bit last);
    in_kind   = 2'(kind);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = 13'(imm);
    in_last   = last;
  endtask

  // Offer one bundle, then check the write cycle and the cycle after it
  task automatic send(input int kind, input int rd, input int rs1, input int rs2,
                      input int f3, input int f7, input int imm, input bit last);
    int waited = 0;
    bit bad;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    drive_fields(kind, rd, rs1, rs2, f3, f7, imm, last);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drive_fields($urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom_range(0, 1));
    @(negedge clk);
    bad = branch_chk && (kind == 3) && ((imm & 1) == 1);
    if (bad) begin
      exp_err = 1'b1;
      if (last) exp_done = 1'b1;
      check("bad_we",    imem_we,  0);
      check("bad_err",   err,      exp_err);
      check("bad_count", count,    exp_cnt);
      check("bad_done",  done,     exp_done);
      check("bad_rdy",   in_ready, !exp_done);
    end else begin
      check("wr_we",    imem_we,    1);
      check("wr_addr",  imem_addr,  exp_ptr);
      check("wr_wdata", imem_wdata, ref_encode(kind, rd, rs1, rs2, f3, f7, imm));
      check("wr_rdy",   in_ready,   0);
      check("wr_busy",  busy,       1);
      exp_ptr = (exp_ptr + 1) % (1 << ADDR_W);
      exp_cnt++;
      if (last || exp_cnt == DEPTH) exp_done = 1'b1;
      @(negedge clk);
      check("post_we",    imem_we,  0);
      check("post_count", count,    exp_cnt);
      check("post_done",  done,     exp_done);
      check("post_full",  full,     exp_cnt == DEPTH);
      check("post_rdy",   in_ready, !exp_done);
      check("post_busy",  busy,     !exp_done);
      check("post_err",   err,      exp_err);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    drive_fields(0, 0, 0, 0, 0, 0, 0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // in_valid in IDLE is ignored
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_valid_we",    imem_we, 0);
    check("idle_valid_count", count,   0);
    in_valid = 1'b0;

    // Directed program: lw, sw, add, beq(last); start with a simultaneous in_valid
    do_start(1'b1);
    send(0, 5, 2, 0, 0, 0, 8, 1'b0);
    send(1, 0, 2, 6, 0, 0, 12, 1'b0);
    send(2, 3, 1, 2, 0, 0, 0, 1'b0);
    send(3, 0, 1, 2, 0, 0, 8, 1'b1);
    check("prog_done", done, 1);
    check("prog_busy", busy, 0);

    // Restart begins again at the base address
    do_start(1'b0);
    send(0, 1, 1, 0, 0, 0, 4, 1'b0);

    // start during ACCEPT is ignored
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("acc_start_count", count,    1);
    check("acc_start_rdy",   in_ready, 1);
    send(0, 1, 1, 0, 0, 0, 4, 1'b1);

    // Fill the session with sub x3,x1,x2 and no last flag
    do_start(1'b0);
    for (int i = 0; i < DEPTH; i++) send(2, 3, 1, 2, 0, 'h20, 0, 1'b0);
    check("fill_full", full, 1);
    check("fill_done", done, 1);
    drive_fields(2, 3, 1, 2, 0, 'h20, 0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("extra_rdy",   in_ready, 0);
      check("extra_we",    imem_we,  0);
      check("extra_count", count,    DEPTH);
    end
    in_valid = 1'b0;

    // Odd beq offset: dropped with err when checked, else written with bit 0 discarded
    do_start(1'b0);
    send(3, 0, 0, 0, 0, 0, 'h005, 1'b0);
    send(0, 7, 3, 0, 0, 0, 'h7ff, 1'b1);

    // Reset asserted in the middle of a write
    do_start(1'b0);
    drive_fields(1, 0, 4, 9, 0, 0, 'h3f, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_we", imem_we, 1);
    reset = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    check_all_zero("post_rst");

    // Randomized sessions
    for (int s = 0; s < 10; s++) begin
      do_start($urandom_range(0, 1));
      for (int i = 0; i < 20 && !exp_done; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127),
             $urandom_range(0, 8191), ($urandom_range(0, 4) == 0) || (i == 19));
      end
      check("rand_done", done, exp_done);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Sequential program loader, the encoder-side counterpart of the control-path main decoder.
- Accepts instruction field bundles (lw, sw, R-type, beq) over a valid/ready handshake.
- Packs each bundle into a 32-bit RV32I word and writes it to consecutive instruction-memory word addresses.
- Sits between the bench/boot source and the instruction memory write port. It feeds the opcodes that the decoder later consumes.

Parameters:
- ADDR_W, 6: instruction-memory word-address width.
- DEPTH, 64: maximum words per load session; must be ≤ 2**ADDR_W.
- BASE_ADDR, 0: word address of the first write in a session.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle pulse that opens a load session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle.
- in_kind  in  2  instruction kind: 00 lw, 01 sw, 10 R-type, 11 beq.
- in_rd  in  5  destination register (lw, R-type).
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2 (sw, R-type, beq).
- in_funct3  in  3  R-type funct3; ignored for other kinds.
- in_funct7  in  7  R-type funct7; ignored for other kinds.
- in_imm  in  13  immediate. lw/sw use [11:0]. beq uses [12:1] as a byte offset.
- in_last  in  1  marks the final bundle of the session.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- busy  out  1  high in ACCEPT or WRITE.
- done  out  1  session finished; held until the next start.
- full  out  1  count == DEPTH.
- err  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; internal pointer = BASE_ADDR; state IDLE.
- Reset asserted mid-session aborts the session immediately. No partial write occurs after reset.
- Encoding rules; fields are taken from the bundle as accepted:
  - lw: imm[11:0], rs1, 010, rd, 0000011.
  - sw: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011.
  - R-type: funct7, rs2, rs1, funct3, rd, 0110011.
  - beq: imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011.
- Unused fields for a given kind are ignored.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
  - IDLE: in_ready=0. start → ACCEPT with count=0, ptr=BASE_ADDR, err cleared.
  - ACCEPT: in_ready=1. On in_valid&&in_ready, encoded word, ptr and last flag are registered → WRITE.
  - WRITE: in_ready=0; imem_we=1 for exactly one cycle with imem_addr=ptr and imem_wdata=registered word. Then ptr+1 and count+1.
    - → DONE if the captured last flag is set or count reaches DEPTH.
    - Otherwise → ACCEPT.
  - DONE: done=1 and in_ready=0. start → ACCEPT, clearing done, count and full, and resetting ptr to BASE_ADDR.
- Latency: a word accepted at edge N is written during cycle N+1. Throughput is one word per 2 cycles.
- start is ignored in ACCEPT and WRITE.
- in_valid is ignored in IDLE, WRITE and DONE.
- Full: the DEPTH-th write forces DONE with full=1 even if in_last=0.
- Address wrap: ptr increments modulo 2**ADDR_W.
- A simultaneous start and in_valid in IDLE/DONE only starts the session; the bundle is not accepted in that cycle.

Optional Feature:
- Macro: ENCLD_BRANCH_CHECK_EN.
- With the macro defined:
  - A beq bundle with in_imm[0]=1 is accepted, but no WRITE occurs.
  - err is set and stays sticky until the next start.
  - FSM stays in ACCEPT; count is unchanged.
  - If that bundle carried in_last, the FSM goes to DONE.
- Without the macro: in_imm[0] is silently dropped, and err is tied to 0.

Decomposition:
- Shared package riscv_enc_pkg holds:
  - opcode constants: OP_LW 0000011, OP_SW 0100011, OP_R 0110011, OP_BEQ 1100011;
  - the kind encoding constants;
  - funct3 constants F3_W=010 and F3_BEQ=000;
  - the FSM state typedef.
- One combinational sub-module, instr_field_packer (fields in, 32-bit word out), is natural. The FSM, pointer and counters stay in the top.

Test Plan:
- start, then lw rd=5 rs1=2 imm=8 with last=0 → one cycle after accept: imem_we=1, addr=0, wdata=0x00812283, count=1.
- sw rs2=6 rs1=2 imm=12, then R-type funct7=0 rs2=2 rs1=1 f3=0 rd=3 → addr 1 wdata 0x00612623, then addr 2 wdata 0x002081B3; in_ready low during each WRITE cycle.
- beq rs1=1 rs2=2 imm=8 last=1 → wdata 0x00208463, then done=1 and busy=0. A later start restarts at addr 0 with count=0.
- R-type funct7=0100000 (sub x3,x1,x2) streamed with DEPTH=4, last never asserted → 4 writes of 0x402081B3, then full=1 and done=1; a fifth in_valid is not accepted.
- Reset pulsed during WRITE → imem_we=0 at once; all outputs 0; state IDLE.
- With ENCLD_BRANCH_CHECK_EN: beq imm=0x005 → no imem_we, err=1, count unchanged. Without the macro: the same bundle writes 0x00000263 (beq x0,x0,+4).
